// File: rtl/calc1_port_responder.sv
// calc1_port_responder: calc1 command responder with add/sub/shift and a configurable execution latency
module calc1_port_responder #(
  parameter int LATENCY = 2
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:1]  out_resp,
  output logic [0:31] out_data,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, OP2, EXEC, RESP} state_t;
  localparam logic [0:1] RESP_OK  = 2'b01;
  localparam logic [0:1] RESP_ERR = 2'b10;
  state_t      state, state_n;
  logic [0:3]  cmd;
  logic [0:31] op1, op2;
  logic [3:0]  cnt;
  logic [0:1]  res_resp, calc_resp;
  logic [0:31] res_data, calc_data;
  logic [32:0] sum;
  logic        accept, done;
  // A new command is taken in IDLE or on the edge that clears the response
  assign accept = (state == IDLE || state == RESP) && req_cmd_in != 4'b0000;
  assign done   = state == EXEC && cnt == 4'd0;
  // State register
  always_ff @(posedge c_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  // Next-state logic
  always_comb begin
    state_n = accept ? OP2 :
              state == OP2 ? EXEC :
              done ? RESP :
              state == RESP ? IDLE : state;
  end
  // Operand capture, latency counter and result register
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cmd      <= '0;
      op1      <= '0;
      op2      <= '0;
      cnt      <= '0;
      res_resp <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        cmd <= req_cmd_in;
        op1 <= req_data_in;
      end
      if (state == OP2) begin
        op2 <= req_data_in;
        cnt <= 4'(LATENCY - 1);
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        res_resp <= calc_resp;
        res_data <= calc_data;
      end
    end
  end
  // Execution datapath; any error forces the data to zero
  always_comb begin
    sum       = {1'b0, op1} + {1'b0, op2};
    calc_resp = RESP_ERR;
    calc_data = '0;
    case (cmd)
      4'b0001: begin
        calc_resp = sum[32] ? RESP_ERR : RESP_OK;
        calc_data = sum[32] ? '0 : sum[31:0];
      end
      4'b0010: begin
        calc_resp = op2 > op1 ? RESP_ERR : RESP_OK;
        calc_data = op2 > op1 ? '0 : op1 - op2;
      end
      4'b0101: begin
        calc_resp = RESP_OK;
        calc_data = op1 << op2[27:31];
      end
      4'b0110: begin
        calc_resp = RESP_OK;
        calc_data = op1 >> op2[27:31];
      end
      default: begin
        calc_resp = RESP_ERR;
        calc_data = '0;
      end
    endcase
  end
  // Outputs: response only during RESP, busy whenever a command is in flight
  always_comb begin
    out_resp = state == RESP ? res_resp : 2'b00;
    out_data = state == RESP ? res_data : '0;
    busy     = state != IDLE;
  end
endmodule

// File: tb/tb_calc1_port_responder.sv
// tb_calc1_port_responder: scoreboard bench for calc1_port_responder
module tb_calc1_port_responder;
  localparam int L = 2;
  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_cmd_in = '0;
  logic [31:0] req_data_in = '0;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        busy;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  typedef struct {
    logic [1:0]  r;
    logic [31:0] d;
    int          c;
  } exp_t;
  exp_t q[$];

  calc1_port_responder #(.LATENCY(L)) dut (
    .c_clk(c_clk),
    .reset(reset),
    .req_cmd_in(req_cmd_in),
    .req_data_in(req_data_in),
    .out_resp(out_resp),
    .out_data(out_data),
    .busy(busy)
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] s;
    s = 64'(a) + 64'(b);
    case (c)
      4'd1: return s > 64'hFFFF_FFFF ? {2'b10, 32'd0} : {2'b01, s[31:0]};
      4'd2: return b > a ? {2'b10, 32'd0} : {2'b01, a - b};
      4'd5: return {2'b01, a << b[4:0]};
      4'd6: return {2'b01, a >> b[4:0]};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  // Pop and compare on every response; any response with nothing queued is an error
  always @(negedge c_clk) begin
    if (out_resp != 2'b00) begin
      if (q.size() == 0) check("unexpected_resp", 64'(out_resp), 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("resp", 64'(out_resp), 64'(e.r));
        check("data", 64'(out_data), 64'(e.d));
        check("resp_cycle", 64'(cyc), 64'(e.c));
      end
    end else check("idle_data", 64'(out_data), 64'd0);
  end

  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] r, input logic [31:0] d, input bit push = 1'b1);
    @(negedge c_clk);
    req_cmd_in  = c;
    req_data_in = a;
    @(negedge c_clk);
    req_cmd_in  = 4'd0;
    req_data_in = b;
    check("busy_capture", 64'(busy), 64'd1);
    if (push) q.push_back('{r, d, cyc + 1 + L});
  endtask

  task automatic send_m(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [33:0] m;
    m = model(c, a, b);
    send(c, a, b, m[33:32], m[31:0]);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge c_clk);
    check("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    repeat (8) begin
      @(negedge c_clk);
      check("rst_resp", 64'(out_resp), 64'd0);
      check("rst_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge c_clk);
      check("idle_resp", 64'(out_resp), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
    end
    send(4'd5, 32'd1, 32'd31, 2'b01, 32'h8000_0000); drain();
    send(4'd5, 32'd3, 32'd31, 2'b01, 32'h8000_0000); drain();
    send(4'd5, 32'd5, 32'd0, 2'b01, 32'd5); drain();
    send(4'd6, 32'd20, 32'd2, 2'b01, 32'd5); drain();
    send(4'd6, 32'hFFFF_FFFF, 32'h0000_0021, 2'b01, 32'h7FFF_FFFF); drain();
    send(4'd1, 32'hFFFF_FFFF, 32'd1, 2'b10, 32'd0); drain();
    send(4'd2, 32'd3, 32'd5, 2'b10, 32'd0); drain();
    send(4'd2, 32'd5, 32'd3, 2'b01, 32'd2); drain();
    send(4'd15, 32'd7, 32'd9, 2'b10, 32'd0); drain();
    send(4'd3, 32'd7, 32'd9, 2'b10, 32'd0); drain();
    send(4'd1, 32'd100, 32'd23, 2'b01, 32'd123); drain();
    for (int a = 0; a <= 20; a++)
      for (int b = 0; b < 32; b++) begin
        send_m(4'd5, 32'(a), 32'(b));
        drain();
      end
    for (int a = 0; a <= 20; a++)
      for (int b = 0; b < 32; b++) begin
        send_m(4'd6, 32'(a), 32'(b));
        drain();
      end
    for (int i = 0; i < 40; i++) begin
      send_m(4'd6, $urandom, ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 31)));
      drain();
      send_m(4'd1, $urandom, $urandom);
      drain();
      send_m(4'd2, $urandom, $urandom);
      drain();
    end
    send(4'd1, 32'd10, 32'd20, 2'b01, 32'd30);
    @(negedge c_clk);
    req_cmd_in  = 4'd2;
    req_data_in = 32'd1;
    @(negedge c_clk);
    req_cmd_in  = 4'd0;
    drain();
    repeat (6) @(negedge c_clk);
    send(4'd1, 32'd1, 32'd2, 2'b01, 32'd3);
    repeat (L) @(negedge c_clk);
    send(4'd2, 32'd9, 32'd4, 2'b01, 32'd5);
    drain();
    repeat (3) @(negedge c_clk);
    send(4'd1, 32'd7, 32'd8, 2'b01, 32'd15, 1'b0);
    @(negedge c_clk);
    reset = 1'b1;
    @(negedge c_clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge c_clk);
    send(4'd1, 32'd2, 32'd3, 2'b01, 32'd5);
    drain();
    repeat (4) @(negedge c_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
